fifo_pkt_writer: RTL and testbench
==================================

FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 Parameter WIDTH, default 8, sets the data word width of the stream and the FIFO write port.
REQ-002 Parameter MAX_LEN, default 16, sets the maximum payload words per packet (range 2..256).
REQ-003 Parameter THROTTLE, default 1, where 1 means at most one FIFO write every two wr_clk cycles.
REQ-004 wr_clk  input  1  write-domain clock; all state changes on its rising edge.
REQ-005 wr_rstn  input  1  asynchronous active-low reset.
REQ-006 s_data  input  WIDTH  upstream payload word.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_last  input  1  marks the final payload word of a packet; qualified by s_valid.
REQ-009 s_ready  output  1  writer accepts s_data this cycle.
REQ-010 fifo_full  input  1  full flag from the async FIFO write side.
REQ-011 wr_en  output  1  FIFO write strobe; each asserted cycle is one committed write.
REQ-012 wr_data  output  WIDTH  FIFO write word.
REQ-013 pkt_done  output  1  one-cycle pulse when a tail word is written.
REQ-014 pkt_trunc  output  1  one-cycle pulse, coincident with pkt_done, when the packet was cut at MAX_LEN.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, DATA and TAIL.
REQ-017 Transfer: gate = !fifo_full & !hold; hold = THROTTLE & (wr_en was high last cycle); with THROTTLE=0, hold = 0.
REQ-018 In IDLE: wr_en=0, s_ready=0; s_valid=1 -> HDR next cycle, with no word consumed.
REQ-019 In HDR: wr_en=gate, wr_data=seq (WIDTH-bit packet sequence number, zero-extended or truncated to WIDTH); when wr_en=1 -> DATA.
REQ-020 In DATA: s_ready=gate; wr_en=s_valid&gate; wr_data=s_data, combinational pass-through.
REQ-021 Each DATA write SHALL update csum <= csum ^ s_data and len <= len+1, where len is a $clog2(MAX_LEN)+1-bit counter cleared on entry to HDR.
REQ-022 A DATA write with s_last=1 SHALL go to TAIL with trunc=0.
REQ-023 A DATA write with s_last=0 where it is the MAX_LEN-th word SHALL go to TAIL with trunc=1; the next upstream word starts a new packet.
REQ-024 In TAIL: wr_en=gate, wr_data = csum including the final payload word; when wr_en=1 -> IDLE.
REQ-025 On the TAIL write, the block SHALL pulse pkt_done (and pkt_trunc if trunc=1) the following cycle, increment seq modulo 2^WIDTH, and clear csum.
REQ-026 fifo_full=1 SHALL force wr_en=0 and s_ready=0 in every state; the state and data SHALL be held, and no word is lost or duplicated.
REQ-027 Upstream s_valid deasserting mid-packet in DATA SHALL stall the FSM with no timeout.
REQ-028 s_last on a word that is not accepted (s_ready=0) SHALL have no effect.
REQ-029 The packet format in the FIFO SHALL be header, 1..MAX_LEN payload words, then tail; no empty packets.
REQ-030 seq SHALL wrap from 2^WIDTH-1 to 0 without any flag.

Reset
REQ-031 Asserting wr_rstn low SHALL immediately force state=IDLE, seq=0, csum=0, len=0, trunc=0, hold=0, wr_en=0, s_ready=0, pkt_done=0, pkt_trunc=0, busy=0.
REQ-032 Reset mid-packet SHALL abandon the packet without a tail, and the next packet SHALL use seq=0.
REQ-033 Reset release SHALL be synchronous to wr_clk; the first s_valid after release enters HDR on the following edge.

Verification
REQ-034 Scenario: THROTTLE=0, fifo_full=0, send 3-word packet 0x11,0x22,0x33 (last on 0x33) -> FIFO receives 0x00,0x11,0x22,0x33,0x00 on consecutive wr_en cycles; pkt_done pulses once.
REQ-035 Scenario: second packet 0xA5 only -> FIFO receives 0x01,0xA5,0xA5; seq advances to 2.
REQ-036 Scenario: MAX_LEN=4, 6 words 1..6 without s_last then s_last on 6 -> packet 1 is hdr 0x00,1,2,3,4,tail 0x04 with pkt_trunc=1; packet 2 is hdr 0x01,5,6,tail 0x03.
REQ-037 Scenario: fifo_full asserted for 5 cycles mid-DATA -> wr_en=0 and s_ready=0 throughout; the same word is written exactly once after release.
REQ-038 Scenario: THROTTLE=1, continuous stream -> wr_en is never high on two consecutive cycles; data order is unchanged.
REQ-039 Scenario: wr_rstn pulsed low in DATA after 2 words -> outputs reset immediately; the next packet header is 0x00 and its checksum excludes the pre-reset words.

Source files
------------

// File: rtl/fifo_pkt_writer.sv
// Frames an upstream word stream into FIFO packets: a sequence-number header,
// 1..MAX_LEN payload words, then an XOR checksum tail.
module fifo_pkt_writer #(
    parameter int WIDTH    = 8,
    parameter int MAX_LEN  = 16,
    parameter int THROTTLE = 1
) (
    input  logic             wr_clk,
    input  logic             wr_rstn,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             pkt_done,
    output logic             pkt_trunc,
    output logic             busy
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, TAIL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic             hold_q;
    logic             pktDone_q, pktTrunc_q;
    logic             gate, dataWr, tailWr, lenMax;

    assign gate   = !fifo_full && !hold_q;
    assign dataWr = (state_q == DATA) && s_valid && gate;
    assign tailWr = (state_q == TAIL) && gate;
    // True while the word being written would be the MAX_LEN-th of the packet.
    assign lenMax = (len_q == LEN_W'(MAX_LEN - 1));

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid) state_d = HDR;
            HDR:     if (gate) state_d = DATA;
            DATA:    if (dataWr && (s_last || lenMax)) state_d = TAIL;
            TAIL:    if (gate) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        s_ready = 1'b0;
        wr_data = '0;
        case (state_q)
            HDR: begin
                wr_en   = gate;
                wr_data = seq_q;
            end
            DATA: begin
                s_ready = gate;
                wr_en   = dataWr;
                wr_data = s_data;
            end
            TAIL: begin
                wr_en   = gate;
                wr_data = csum_q;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign pkt_done  = pktDone_q;
    assign pkt_trunc = pktTrunc_q;

    always_comb begin
        seq_d   = seq_q;
        csum_d  = csum_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        if ((state_q == IDLE) && s_valid) begin
            len_d   = '0;
            trunc_d = 1'b0;
        end
        if (dataWr) begin
            csum_d  = csum_q ^ s_data;
            len_d   = len_q + 1'b1;
            trunc_d = !s_last && lenMax;
        end
        if (tailWr) begin
            seq_d  = seq_q + 1'b1;
            csum_d = '0;
        end
    end

    // The throttle hold simply remembers last cycle's write strobe.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            seq_q      <= '0;
            csum_q     <= '0;
            len_q      <= '0;
            trunc_q    <= 1'b0;
            hold_q     <= 1'b0;
            pktDone_q  <= 1'b0;
            pktTrunc_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            len_q      <= len_d;
            trunc_q    <= trunc_d;
            hold_q     <= (THROTTLE != 0) ? wr_en : 1'b0;
            pktDone_q  <= tailWr;
            pktTrunc_q <= tailWr && trunc_q;
        end
    end
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer: an unthrottled and a throttled instance,
// driven one at a time against a packet-level reference model.
module tb_fifo_pkt_writer;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int WAIT_LIMIT = 200;

    typedef struct packed {
        logic             inst;
        logic             isTail;
        logic             trunc;
        logic [WIDTH-1:0] data;
    } expT;

    logic             wrClk = 1'b0;
    logic             wrRstn;
    logic [WIDTH-1:0] sData [2];
    logic             sValid [2];
    logic             sLast [2];
    logic             sReady [2];
    logic             fifoFull [2];
    logic             wrEn [2];
    logic [WIDTH-1:0] wrData [2];
    logic             pktDone [2];
    logic             pktTrunc [2];
    logic             busy [2];

    expT              expQ [$];
    logic [WIDTH-1:0] mSeq [2];
    logic [WIDTH-1:0] mCsum [2];
    int               mCnt [2];
    logic             randFull;
    int               nChecks;
    int               nPass;

    always #5 wrClk = ~wrClk;

    fifo_pkt_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .THROTTLE(0)) dut0 (
        .wr_clk(wrClk), .wr_rstn(wrRstn), .s_data(sData[0]), .s_valid(sValid[0]),
        .s_last(sLast[0]), .s_ready(sReady[0]), .fifo_full(fifoFull[0]),
        .wr_en(wrEn[0]), .wr_data(wrData[0]), .pkt_done(pktDone[0]),
        .pkt_trunc(pktTrunc[0]), .busy(busy[0])
    );

    fifo_pkt_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .THROTTLE(1)) dut1 (
        .wr_clk(wrClk), .wr_rstn(wrRstn), .s_data(sData[1]), .s_valid(sValid[1]),
        .s_last(sLast[1]), .s_ready(sReady[1]), .fifo_full(fifoFull[1]),
        .wr_en(wrEn[1]), .wr_data(wrData[1]), .pkt_done(pktDone[1]),
        .pkt_trunc(pktTrunc[1]), .busy(busy[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mSeq[i]  = '0;
            mCsum[i] = '0;
            mCnt[i]  = 0;
        end
    endtask

    // Packet-level model: a packet closes on s_last or after MAX_LEN words.
    task automatic modelWord(input int idx, input logic [WIDTH-1:0] d, input logic last);
        if (mCnt[idx] == 0)
            expQ.push_back('{inst: idx[0], isTail: 1'b0, trunc: 1'b0, data: mSeq[idx]});
        expQ.push_back('{inst: idx[0], isTail: 1'b0, trunc: 1'b0, data: d});
        mCsum[idx] = mCsum[idx] ^ d;
        mCnt[idx]++;
        if (last || mCnt[idx] == MAX_LEN) begin
            expQ.push_back('{inst: idx[0], isTail: 1'b1, trunc: !last, data: mCsum[idx]});
            mSeq[idx]  = mSeq[idx] + 1'b1;
            mCsum[idx] = '0;
            mCnt[idx]  = 0;
        end
    endtask

    task automatic driveFull(input int idx);
        if (randFull) fifoFull[idx] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idleCycles(input int idx, input int n);
        sValid[idx] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge wrClk);
            #1;
            driveFull(idx);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] d, input logic last,
                                 input logic stall);
        int waitCnt;
        modelWord(idx, d, last);
        sData[idx]  = d;
        sLast[idx]  = last;
        sValid[idx] = 1'b1;
        if (stall) begin
            fifoFull[idx] = 1'b1;
            repeat (5) begin
                @(posedge wrClk);
                #1;
            end
            fifoFull[idx] = 1'b0;
        end
        waitCnt = 0;
        forever begin
            @(negedge wrClk);
            if (sReady[idx]) break;
            waitCnt++;
            if (waitCnt > WAIT_LIMIT) begin
                nChecks++;
                $display("[TB] FAIL acceptTimeout: inst %0d word 0x%0h not accepted in %0d cycles",
                         idx, d, WAIT_LIMIT);
                break;
            end
            @(posedge wrClk);
            #1;
            driveFull(idx);
        end
        @(posedge wrClk);
        #1;
        sValid[idx] = 1'b0;
        driveFull(idx);
    endtask

    task automatic drain(input int idx);
        int waitCnt;
        randFull      = 1'b0;
        fifoFull[idx] = 1'b0;
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 500) begin
            @(posedge wrClk);
            #1;
            waitCnt++;
        end
        checkOutput("drainRemaining", 32'(expQ.size()), 32'(0));
        idleCycles(idx, 3);
    endtask

    task automatic resetPulse();
        wrRstn = 1'b0;
        #1;
        checkOutput("resetImmediate",
                    32'({wrEn[0], sReady[0], busy[0], pktDone[0], pktTrunc[0]}), 32'(0));
        checkOutput("abandonedWrites", 32'(expQ.size()), 32'(0));
        modelReset();
        expQ.delete();
        repeat (2) @(posedge wrClk);
        #1;
        wrRstn = 1'b1;
    endtask

    task automatic randomPackets(input int idx, input int n, input logic fullOn);
        int len;
        randFull = fullOn;
        for (int p = 0; p < n; p++) begin
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                applyStimulus(idx, WIDTH'($urandom), (w == len - 1), 1'b0);
                if (fullOn && $urandom_range(0, 3) == 0) idleCycles(idx, $urandom_range(1, 3));
            end
            idleCycles(idx, $urandom_range(0, 2));
        end
    endtask

    // Monitor: pops the scoreboard on every write and tracks the done/trunc pulses.
    initial begin
        expT  e;
        logic donePend [2];
        logic truncPend [2];
        logic prevWr [2];
        logic newPend, newTrunc;
        for (int i = 0; i < 2; i++) begin
            donePend[i]  = 1'b0;
            truncPend[i] = 1'b0;
            prevWr[i]    = 1'b0;
        end
        forever begin
            @(negedge wrClk);
            for (int i = 0; i < 2; i++) begin
                if (!wrRstn) begin
                    donePend[i]  = 1'b0;
                    truncPend[i] = 1'b0;
                    prevWr[i]    = 1'b0;
                end else begin
                    newPend  = 1'b0;
                    newTrunc = 1'b0;
                    if (fifoFull[i])
                        checkOutput("fullBlocks", 32'({wrEn[i], sReady[i]}), 32'(0));
                    if (wrEn[i]) begin
                        if (expQ.size() == 0) begin
                            nChecks++;
                            $display("[TB] FAIL unexpectedWrite: inst %0d wrote 0x%0h, required no write",
                                     i, wrData[i]);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("wrData", 32'({i[0], wrData[i]}), 32'({e.inst, e.data}));
                            newPend  = e.isTail;
                            newTrunc = e.isTail && e.trunc;
                        end
                        if (i == 1) checkOutput("throttleGap", 32'(prevWr[i]), 32'(0));
                    end
                    if (donePend[i] || pktDone[i] || pktTrunc[i])
                        checkOutput("pktDoneTrunc", 32'({pktDone[i], pktTrunc[i]}),
                                    32'({donePend[i], truncPend[i]}));
                    donePend[i]  = newPend;
                    truncPend[i] = newTrunc;
                    prevWr[i]    = wrEn[i];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nChecks  = 0;
        nPass    = 0;
        randFull = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sData[i]    = '0;
            sValid[i]   = 1'b0;
            sLast[i]    = 1'b0;
            fifoFull[i] = 1'b0;
        end
        modelReset();
        wrRstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            checkOutput("resetState",
                        32'({wrEn[i], sReady[i], busy[i], pktDone[i], pktTrunc[i]}), 32'(0));
        repeat (3) @(posedge wrClk);
        #1;
        wrRstn = 1'b1;
        idleCycles(0, 2);
        checkOutput("idleAfterRelease", 32'({busy[0], busy[1]}), 32'(0));

        applyStimulus(0, 8'h11, 1'b0, 1'b0);
        applyStimulus(0, 8'h22, 1'b0, 1'b0);
        applyStimulus(0, 8'h33, 1'b1, 1'b0);
        idleCycles(0, 4);
        applyStimulus(0, 8'hA5, 1'b1, 1'b0);
        idleCycles(0, 4);

        // Third packet (seq 2) stalls on full mid-DATA, then is abandoned by reset.
        applyStimulus(0, 8'h5A, 1'b0, 1'b0);
        applyStimulus(0, 8'h3C, 1'b0, 1'b1);
        resetPulse();

        for (int k = 1; k <= 6; k++) applyStimulus(0, WIDTH'(k), (k == 6), 1'b0);
        idleCycles(0, 6);
        drain(0);

        randomPackets(0, 40, 1'b1);
        drain(0);
        randomPackets(1, 20, 1'b0);
        randomPackets(1, 260, 1'b1);
        drain(1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
